phase_timer_ctrl: RTL and testbench
===================================

# phase_timer_ctrl

Four-phase sequencer that owns one programmable down-counter and steps it through four programmable durations, one per phase, counting only on `cei` enable ticks. It sits between a tick source (e.g. a 10 Hz enable) and phase-driven logic such as lights, displays or lab-board outputs. It schedules the timer: it loads each duration, detects terminal count, advances phases, and handles hold, skip and abort.

## Interface
- `CNT_W`, 24: counter width.
- `DUR0`, 24'd5000000: phase 0 length, in `cei` ticks. Legal range is 1..2^CNT_W−1; 0 is illegal.
- `DUR1`, 24'd5000000: phase 1 length, same rules as `DUR0`.
- `DUR2`, 24'd5000000: phase 2 length, same rules as `DUR0`.
- `DUR3`, 24'd5000000: phase 3 length, same rules as `DUR0`.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cei` in 1: count-enable tick; counter decrements only when high.
- `start` in 1: begin sequence from phase 0; honoured only in IDLE.
- `loop` in 1: sampled at phase-3 completion. 1 means wrap to phase 0; 0 means finish.
- `hold` in 1: level signal; freezes counting while high.
- `skip` in 1: force immediate completion of the current phase.
- `abort` in 1: return to IDLE.
- `phase` out 2: current phase index.
- `count` out CNT_W: remaining ticks minus 1 in the current phase.
- `busy` out 1: high in RUN or HOLD.
- `held` out 1: high in HOLD.
- `phase_done` out 1: one-cycle pulse on each phase completion.
- `seq_done` out 1: one-cycle pulse when a non-looping sequence ends.

## Operation
- **States:** IDLE, RUN, HOLD. The state and every output are registered.
- **Reset** (asynchronous, while `reset`=0): state IDLE, `phase`=0, `count`=0, `busy`=0, `held`=0, `phase_done`=0, `seq_done`=0.
- **IDLE:**
  - `start`=1 (and `abort`=0) → RUN, `phase`←0, `count`←DUR0−1.
  - All other inputs are ignored. `count` holds its value.
- **RUN, evaluated each clock in priority order** abort > skip > hold > cei:
  - `abort`: → IDLE, `phase`←0, `count`←0. No pulses.
  - `skip`: complete the phase (see Completion). `cei` is not required.
  - `hold`: → HOLD. `count` is frozen and this cycle's `cei` is ignored.
  - `cei` and `count`≠0: `count`←`count`−1.
  - `cei` and `count`=0: complete the phase (see Completion).
  - Otherwise: no change.
- **HOLD:**
  - `abort` → IDLE.
  - `skip` completes the phase and → RUN, even while `hold` is high. If `hold` is still high on the next cycle, the block re-enters HOLD.
  - `hold`=0 → RUN. Counting resumes on the next cycle; `cei` in this exit cycle is ignored.
  - Otherwise: remain in HOLD.
- **Completion, phase p:**
  - `phase_done`←1 for one cycle.
  - If p<3: `phase`←p+1, `count`←DUR(p+1)−1, stay RUN.
  - If p=3 and `loop`=1: `phase`←0, `count`←DUR0−1, stay RUN.
  - If p=3 and `loop`=0: → IDLE, `phase`←0, `count`←0, `seq_done`←1.
- **Arithmetic:** the DURn−1 constants are computed at elaboration, CNT_W bits wide. `count` never wraps below 0.
- **`start`:** ignored while busy; restarting requires `abort` first.

## Timing
- **Start latency:** `start` sampled at edge k → `busy`=1, `phase`=0, `count`=DUR0−1 after edge k.
- **Phase length:** with `cei` continuously high, phase p lasts exactly DURp clock cycles. With `cei`=1 once every N clocks, phase p lasts DURp ticks.
- **Back-to-back phases:** the next phase's count is loaded on the same edge that completes the current phase, so there are no dead cycles.
- **`phase_done`:** high during the first cycle of the new phase, or during the first IDLE cycle at sequence end. `seq_done` coincides with the final `phase_done`.
- **Pulse width:** both pulses are cleared on the following edge unless another completion occurs there. With DURn=1 and `cei`=1, `phase_done` stays high on consecutive cycles.
- **Abort:** takes effect on the next edge and overrides a coincident completion.
- **Mid-sequence reset:** `reset` low clears all outputs immediately, independent of `clk`. On release, the block is in IDLE and waits for `start`.

## Test plan
Unless noted, the bench uses DUR0=3, DUR1=2, DUR2=4, DUR3=1 and `cei`=1 every cycle.

- **Single pass:** `loop`=0, `start` pulse → `phase` sequence 0,0,0,1,1,2,2,2,2,3 over 10 cycles. `phase_done` pulses 4 times. `seq_done`=1 on cycle 11, together with `busy`=0.
- **Loop:** `loop`=1 → after phase 3, `phase`=0 and `count`=2 on the same edge, `busy` stays 1, and `seq_done` never asserts.
- **Hold:** `hold` asserted at phase 2 with `count`=2, for 5 cycles → `held`=1 and `count` stays at 2. After release, phase 2 completes 3 `cei` ticks later.
- **Skip and abort:** `skip` at phase 0 with `count`=2 → next edge gives `phase`=1, `count`=1, `phase_done`=1. `abort` and `skip` in the same cycle → IDLE, `phase`=0, no pulse.
- **Sparse `cei`:** `cei`=1 every 4 clocks → phase 0 lasts 12 clocks.
- **Reset mid-RUN:** `reset` driven low asynchronously mid-RUN → outputs 0 without a clock edge. After release, `start` is ignored until sampled in IDLE; a repeat run matches the single-pass scenario.

Source files
------------

// File: rtl/phase_timer_ctrl.sv
// rtl/phase_timer_ctrl.sv - four-phase sequencer driving one programmable down-counter
//
// Steps a single down-counter through four programmable phase durations,
// decrementing only on cei ticks, with hold/skip/abort control.
//
// Parameters:
//   CNT_W          counter width
//   DUR0..DUR3     phase lengths in cei ticks (1 .. 2^CNT_W-1)
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   cei            count-enable tick
//   start          begin a sequence at phase 0 (IDLE only)
//   loop           at phase-3 completion: 1 wraps to phase 0, 0 finishes
//   hold           level; freezes counting while high
//   skip           complete the current phase immediately
//   abort          return to IDLE
//   phase          current phase index
//   count          remaining ticks minus one in the current phase
//   busy           high in RUN or HOLD
//   held           high in HOLD
//   phase_done     one-cycle pulse per phase completion
//   seq_done       one-cycle pulse when a non-looping sequence ends
module phase_timer_ctrl #(
  parameter int unsigned      CNT_W = 24,
  parameter logic [CNT_W-1:0] DUR0  = CNT_W'(5000000),
  parameter logic [CNT_W-1:0] DUR1  = CNT_W'(5000000),
  parameter logic [CNT_W-1:0] DUR2  = CNT_W'(5000000),
  parameter logic [CNT_W-1:0] DUR3  = CNT_W'(5000000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cei,
  input  logic             start,
  input  logic             loop,
  input  logic             hold,
  input  logic             skip,
  input  logic             abort,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             held,
  output logic             phase_done,
  output logic             seq_done
);

  localparam logic [CNT_W-1:0] DUR0_M1 = DUR0 - CNT_W'(1);
  localparam logic [CNT_W-1:0] DUR1_M1 = DUR1 - CNT_W'(1);
  localparam logic [CNT_W-1:0] DUR2_M1 = DUR2 - CNT_W'(1);
  localparam logic [CNT_W-1:0] DUR3_M1 = DUR3 - CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       phase_n;
  logic [CNT_W-1:0] count_n;
  logic             phase_done_n;
  logic             seq_done_n;
  logic             complete;

  function automatic logic [CNT_W-1:0] dur_m1(input logic [1:0] p);
    case (p)
      2'd0:    return DUR0_M1;
      2'd1:    return DUR1_M1;
      2'd2:    return DUR2_M1;
      default: return DUR3_M1;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      phase      <= 2'd0;
      count      <= '0;
      busy       <= 1'b0;
      held       <= 1'b0;
      phase_done <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      count      <= count_n;
      busy       <= (state_n != IDLE);
      held       <= (state_n == HOLD);
      phase_done <= phase_done_n;
      seq_done   <= seq_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    count_n      = count;
    phase_done_n = 1'b0;
    seq_done_n   = 1'b0;
    complete     = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = RUN;
          phase_n = 2'd0;
          count_n = DUR0_M1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          phase_n = 2'd0;
          count_n = '0;
        end else if (skip) begin
          complete = 1'b1;
        end else if (hold) begin
          // cei in this cycle is deliberately dropped
          state_n = HOLD;
        end else if (cei) begin
          if (count != '0) count_n = count - CNT_W'(1);
          else             complete = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          state_n = IDLE;
          phase_n = 2'd0;
          count_n = '0;
        end else if (skip) begin
          // skip always returns to RUN; a still-high hold re-enters HOLD next cycle
          complete = 1'b1;
        end else if (!hold) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = 2'd0;
        count_n = '0;
      end
    endcase

    // Next phase is loaded on the completing edge so phases run back to back
    if (complete) begin
      phase_done_n = 1'b1;
      if (phase != 2'd3) begin
        state_n = RUN;
        phase_n = phase + 2'd1;
        count_n = dur_m1(phase + 2'd1);
      end else if (loop) begin
        state_n = RUN;
        phase_n = 2'd0;
        count_n = DUR0_M1;
      end else begin
        state_n    = IDLE;
        phase_n    = 2'd0;
        count_n    = '0;
        seq_done_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_timer_ctrl.sv
// tb/tb_phase_timer_ctrl.sv - self-checking bench for phase_timer_ctrl
module tb_phase_timer_ctrl;

  localparam int CW = 8;
  typedef logic [CW+5:0] vec_t;  // {phase, count, busy, held, phase_done, seq_done}

  logic clk = 1'b0;
  logic rst_n, cei, start, loop, hold, skip, abort;
  logic [1:0]    phase;
  logic [CW-1:0] count;
  logic busy, held, phase_done, seq_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t expq[$];
  vec_t obs, exp_v;
  int   dur[4] = '{3, 2, 4, 1};

  assign obs = {phase, count, busy, held, phase_done, seq_done};

  phase_timer_ctrl #(
    .CNT_W(CW), .DUR0(8'd3), .DUR1(8'd2), .DUR2(8'd4), .DUR3(8'd1)
  ) dut (
    .clk(clk), .reset(rst_n), .cei(cei), .start(start), .loop(loop),
    .hold(hold), .skip(skip), .abort(abort), .phase(phase), .count(count),
    .busy(busy), .held(held), .phase_done(phase_done), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int p, input int c, input bit b, input bit h,
                              input bit pd, input bit sd);
    return {p[1:0], c[CW-1:0], b, h, pd, sd};
  endfunction

  // Expected per-cycle outputs of an uninterrupted pass, derived from the
  // phase durations; the 11th entry is the first IDLE cycle after the pass.
  task automatic push_pass(input int limit, input bit looping);
    int n = 0;
    for (int p = 0; p < 4; p++)
      for (int c = dur[p] - 1; c >= 0; c--)
        if (n < limit) begin
          expq.push_back(mk(p, c, 1'b1, 1'b0, (p > 0 && c == dur[p] - 1), 1'b0));
          n++;
        end
    if (n < limit) begin
      if (looping) expq.push_back(mk(0, dur[0] - 1, 1'b1, 1'b0, 1'b1, 1'b0));
      else         expq.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; loop = 1'b0; hold = 1'b0; skip = 1'b0; abort = 1'b0; cei = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, mk(0, 0, 0, 0, 0, 0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (obs !== mk(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h expected %h", obs, mk(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_single_pass(input string tag);
    int pulses = 0;
    idle_inputs();
    push_pass(11, 1'b0);
    expq.push_back(mk(0, 0, 0, 0, 0, 0));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      exp_v = expq.pop_front();
      pulses += int'(phase_done);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, i + 1, obs, exp_v);
      end
    end
    n_checks++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL %s_pulse_count: got %0d expected 4", tag, pulses);
    end
  endtask

  task automatic test_loop();
    idle_inputs();
    loop = 1'b1;
    push_pass(11, 1'b1);
    expq.push_back(mk(0, 1, 1, 0, 0, 0));
    expq.push_back(mk(0, 0, 0, 0, 0, 0));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) step();
      if (i == 11) abort = 1'b1;
      exp_v = expq.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL loop cycle %0d: got %h expected %h", i + 1, obs, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    idle_inputs();
    push_pass(7, 1'b0);
    repeat (5) expq.push_back(mk(2, 2, 1, 1, 0, 0));
    expq.push_back(mk(2, 2, 1, 0, 0, 0));
    expq.push_back(mk(2, 1, 1, 0, 0, 0));
    expq.push_back(mk(2, 0, 1, 0, 0, 0));
    expq.push_back(mk(3, 0, 1, 0, 1, 0));
    expq.push_back(mk(0, 0, 0, 0, 1, 1));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) step();
      hold = (i >= 6 && i <= 10);
      exp_v = expq.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got %h expected %h", i + 1, obs, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_skip_abort();
    idle_inputs();
    expq.push_back(mk(0, 2, 1, 0, 0, 0));
    expq.push_back(mk(1, 1, 1, 0, 1, 0));
    expq.push_back(mk(1, 0, 1, 0, 0, 0));
    expq.push_back(mk(0, 0, 0, 0, 0, 0));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      skip  = (i == 0 || i == 2);
      abort = (i == 2);
      exp_v = expq.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL skip_abort cycle %0d: got %h expected %h", i + 1, obs, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_sparse_cei();
    int len = 0;
    idle_inputs();
    cei = 1'b0;
    for (int j = 0; j < 12; j++) expq.push_back(mk(0, 2 - j / 4, 1, 0, 0, 0));
    expq.push_back(mk(1, 1, 1, 0, 1, 0));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 13; j++) begin
      if (j > 0) step();
      cei = ((j + 1) % 4 == 0);
      if (phase == 2'd0 && busy) len++;
      exp_v = expq.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL sparse_cei edge %0d: got %h expected %h", j, obs, exp_v);
      end
    end
    n_checks++;
    if (len != 12) begin
      n_fail++;
      $display("FAIL sparse_phase0_len: got %0d expected 12", len);
    end
    cei = 1'b0;
    abort = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    idle_inputs();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs, mk(0, 0, 0, 0, 0, 0));
    end
    start = 1'b1;
    step();
    start = 1'b0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (obs !== mk(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h expected %h", obs, mk(0, 0, 0, 0, 0, 0));
    end
    test_single_pass("repeat_pass");
  endtask

  initial begin
    test_reset();
    test_single_pass("single_pass");
    test_loop();
    test_hold();
    test_skip_abort();
    test_sparse_cei();
    test_reset_mid_run();
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
